// File: rtl/float_pack.sv
// Shared floating-point format, derived constants and the divider FSM states.
// Format widths default to single precision unless TB_MANT_SIZE / TB_EXP_SIZE
// are defined by the build.
`ifndef TB_MANT_SIZE
`define TB_MANT_SIZE 23
`endif
`ifndef TB_EXP_SIZE
`define TB_EXP_SIZE 8
`endif

package float_pack;

    localparam int N_mantisse = `TB_MANT_SIZE;
    localparam int N_exposant = `TB_EXP_SIZE;

    typedef struct packed {
        logic                  signe;
        logic [N_exposant-1:0] exposant;
        logic [N_mantisse-1:0] mantisse;
    } float;

    localparam int D_e     = 2**(N_exposant-1) - 1;
    localparam int EXP_MIN = 1;
    localparam int EXP_MAX = 2**N_exposant - 2;

    // Working exponent: signed, two spare bits for underflow/overflow headroom.
    localparam int EXP_W   = N_exposant + 2;

    // Mantissa datapath widths: significand with hidden bit, remainder with
    // one bit of shift headroom, quotient with integer bit plus guard bit.
    localparam int MANT_W  = N_mantisse + 1;
    localparam int REM_W   = N_mantisse + 2;
    localparam int QUO_W   = N_mantisse + 3;
    localparam int N_STEPS = N_mantisse + 3;
    localparam int CNT_W   = $clog2(N_STEPS + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIVIDE,
        NORM,
        DONE
    } div_state_t;

endpackage

// File: rtl/float_div_mant.sv
// Restoring mantissa divider: one quotient bit per step, N_STEPS steps.
// A step request after the last quotient bit only wraps the counter to 0.
module float_div_mant
    import float_pack::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [MANT_W-1:0] dividend,
    input  logic [MANT_W-1:0] divisor,
    output logic [QUO_W-1:0]  quotient,
    output logic              count_done
);

    logic [REM_W-1:0]  rem_r;
    logic [MANT_W-1:0] div_r;
    logic [QUO_W-1:0]  quo_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [REM_W:0]    diff;

    // Trial subtraction; the top bit is the borrow (negative result).
    always_comb begin
        diff = {1'b0, rem_r} - {2'b00, div_r};
    end

    assign count_done = (cnt_r == CNT_W'(N_STEPS));
    assign quotient   = quo_r;

    // Remainder, quotient and iteration counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_r <= '0;
            div_r <= '0;
            quo_r <= '0;
            cnt_r <= '0;
        end else if (load) begin
            rem_r <= {1'b0, dividend};
            div_r <= divisor;
            quo_r <= '0;
            cnt_r <= '0;
        end else if (step) begin
            if (count_done) begin
                cnt_r <= '0;
            end else begin
                if (!diff[REM_W]) begin
                    rem_r <= diff[REM_W-1:0] << 1;
                end else begin
                    rem_r <= rem_r << 1;
                end
                quo_r <= {quo_r[QUO_W-2:0], ~diff[REM_W]};
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/float_div.sv
// Multi-cycle floating-point divider with fixed latency and saturation.
// Optional build macro FLOAT_DIV_ROUND_EN: round half-up on the guard bit
// instead of truncating.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | capture sign, biased exponent difference and significands
// DIVIDE | restoring division, one quotient bit per cycle, then counter wrap
// NORM   | normalise, round, saturate and register the result
// DONE   | done pulse, result valid
module float_div
    import float_pack::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  float op1,
    input  float op2,
    output logic busy,
    output logic done,
    output float result,
    output logic div_zero
);

    div_state_t       state_r, state_nx;
    logic             sign_r;
    logic [EXP_W-1:0] exp_r;
    logic             op1_zero_r, op2_zero_r;
    logic             mant_load, mant_step, count_done;
    logic [QUO_W-1:0] quotient;

    logic [QUO_W-1:0]      q_norm;
    logic [EXP_W-1:0]      exp_norm, exp_fin;
    logic [N_mantisse-1:0] mant_fin;
    logic                  guard;
    logic                  exp_low, exp_high;
    float                  result_nx;
    logic                  unused_bits;

    float_div_mant u_mant (
        .clk        (clk),
        .reset      (reset),
        .load       (mant_load),
        .step       (mant_step),
        .dividend   ({1'b1, op1.mantisse}),
        .divisor    ({1'b1, op2.mantisse}),
        .quotient   (quotient),
        .count_done (count_done)
    );

    // Next-state and control decode.
    always_comb begin
        state_nx  = state_r;
        busy      = 1'b1;
        done      = 1'b0;
        mant_load = 1'b0;
        mant_step = 1'b0;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                mant_load = 1'b1;
                state_nx  = DIVIDE;
            end
            DIVIDE: begin
                mant_step = 1'b1;
                if (count_done) state_nx = NORM;
            end
            NORM: begin
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Normalise on the integer bit, then optionally round on the guard bit.
    always_comb begin
        q_norm   = quotient;
        exp_norm = exp_r;
        if (!quotient[QUO_W-1]) begin
            q_norm   = quotient << 1;
            exp_norm = exp_r - EXP_W'(1);
        end
        guard    = q_norm[1];
        mant_fin = q_norm[QUO_W-2:2];
        exp_fin  = exp_norm;
`ifdef FLOAT_DIV_ROUND_EN
        if (guard) begin
            if (&mant_fin) begin
                mant_fin = '0;
                exp_fin  = exp_norm + EXP_W'(1);
            end else begin
                mant_fin = mant_fin + 1'b1;
            end
        end
`endif
    end

    assign unused_bits = ^{q_norm[QUO_W-1], q_norm[0], guard};

    // Saturation: divide-by-zero and overflow clamp to the largest finite
    // value; underflow or a zero dividend flushes to signed zero.
    always_comb begin
        exp_low  = exp_fin[EXP_W-1] || (exp_fin < EXP_W'(EXP_MIN));
        exp_high = !exp_fin[EXP_W-1] && (exp_fin > EXP_W'(EXP_MAX));
        result_nx.signe    = sign_r;
        result_nx.exposant = exp_fin[N_exposant-1:0];
        result_nx.mantisse = mant_fin;
        if (op2_zero_r || (!op1_zero_r && !exp_low && exp_high)) begin
            result_nx.exposant = N_exposant'(EXP_MAX);
            result_nx.mantisse = '1;
        end else if (op1_zero_r || exp_low) begin
            result_nx.exposant = '0;
            result_nx.mantisse = '0;
        end
    end

    // State, operand attributes and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            sign_r     <= 1'b0;
            exp_r      <= '0;
            op1_zero_r <= 1'b0;
            op2_zero_r <= 1'b0;
            result     <= '0;
            div_zero   <= 1'b0;
        end else begin
            state_r <= state_nx;
            if (state_r == LOAD) begin
                sign_r     <= op1.signe ^ op2.signe;
                exp_r      <= {2'b00, op1.exposant} - {2'b00, op2.exposant} + EXP_W'(D_e);
                op1_zero_r <= (op1.exposant == '0);
                op2_zero_r <= (op2.exposant == '0);
                div_zero   <= 1'b0;
            end
            if (state_r == NORM) begin
                result   <= result_nx;
                div_zero <= op2_zero_r;
            end
        end
    end

endmodule

// File: tb/tb_float_div.sv
// Directed-vector bench for float_div at single precision.
`timescale 1ns/1ps
module tb_float_div;
    import float_pack::*;

    logic clk = 1'b0;
    logic reset;
    logic start;
    float op1, op2;
    logic busy, done, div_zero;
    float result;

    int checks = 0;
    int errors = 0;

`ifdef FLOAT_DIV_ROUND_EN
    localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
    localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

    float_div dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op1      (op1),
        .op2      (op2),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one division and check result, div_zero, latency, busy and pulse width.
    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res_exp, input logic dz_exp);
        int  lat;
        logic busy_bad;
        logic [31:0] held;
        op1   = a;
        op2   = b;
        start = 1'b1;
        tick();
        start    = 1'b0;
        lat      = 0;
        busy_bad = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (!busy) busy_bad = 1'b1;
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, 29);
        check({tag, "_result"}, result, res_exp);
        check({tag, "_divzero"}, {31'd0, div_zero}, {31'd0, dz_exp});
        check({tag, "_busy"}, {31'd0, busy_bad}, 32'd0);
        held = result;
        tick();
        check({tag, "_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, result, res_exp);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        if (held !== res_exp) $display("note %s: result differed at done", tag);
    endtask

    initial begin
        int  done_at[$];
        logic saw_done;
        logic went_idle;

        reset = 1'b1;
        start = 1'b0;
        op1   = '0;
        op2   = '0;
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_divzero", {31'd0, div_zero}, 32'd0);
        reset = 1'b0;
        tick();

        run_vec("six_by_two",   32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
        run_vec("one_by_three", 32'h3F800000, 32'h40400000, THIRD,        1'b0);
        run_vec("one_by_zero",  32'h3F800000, 32'h00000000, 32'h7F7FFFFF, 1'b1);
        run_vec("big_by_half",  32'h7F61B1E6, 32'h3F000000, 32'h7F7FFFFF, 1'b0);
        run_vec("tiny_by_four", 32'h00D9CEEB, 32'h40800000, 32'h00000000, 1'b0);
        run_vec("zero_by_two",  32'h00000000, 32'h40000000, 32'h00000000, 1'b0);
        run_vec("seven_by_m2",  32'h40E00000, 32'hC0000000, 32'hC0600000, 1'b0);
        run_vec("exp_min_edge", 32'h01000000, 32'h40000000, 32'h00800000, 1'b0);
        run_vec("exp_max_edge", 32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0);
        run_vec("equal_ops",    32'h3FC00000, 32'h3FC00000, 32'h3F800000, 1'b0);
        run_vec("m8_by_two",    32'hC1000000, 32'h40000000, 32'hC0800000, 1'b0);

        // Reset in the middle of an operation.
        op1   = 32'h40C00000;
        op2   = 32'h40000000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_divzero", {31'd0, div_zero}, 32'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        check("midrst_no_done", {31'd0, saw_done}, 32'd0);
        run_vec("after_reset",  32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);

        // start held high for 100 cycles: one request every 31 cycles.
        op1   = 32'h40C00000;
        op2   = 32'h40000000;
        start = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (done) begin
                done_at.push_back(k);
                check("b2b_result", result, 32'h40400000);
            end
        end
        start = 1'b0;
        check("b2b_count", done_at.size(), 3);
        if (done_at.size() == 3) begin
            check("b2b_first", done_at[0], 30);
            check("b2b_gap1", done_at[1] - done_at[0], 31);
            check("b2b_gap2", done_at[2] - done_at[1], 31);
        end
        went_idle = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (!busy) begin
                went_idle = 1'b1;
                break;
            end
        end
        check("b2b_drain", {31'd0, went_idle}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/float_div.md
FLOAT_DIV -- requirements
Module: float_div

Interface
REQ-001 SHALL take parameters N_mantisse (default `TB_MANT_SIZE, 1..23, mantissa bits) and N_exposant (default `TB_EXP_SIZE, 2..8, exponent bits), both imported from float_pack.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op1  input  float  dividend.
REQ-007 op2  input  float  divisor.
REQ-008 busy  output  1  high in every state other than IDLE.
REQ-009 done  output  1  one-cycle pulse; result is valid in that cycle and holds afterwards.
REQ-010 result  output  float  quotient op1/op2.
REQ-011 div_zero  output  1  set together with done when the op2 exponent is 0; holds until the next start.

Function
REQ-012 SHALL implement the FSM IDLE -> LOAD -> DIVIDE -> NORM -> DONE -> IDLE.
- start=1 in IDLE moves to LOAD; start outside IDLE is ignored.
REQ-013 LOAD SHALL register sign = op1.signe ^ op2.signe and exp = op1.exposant - op2.exposant + (2**(N_exposant-1)-1).
- exp is held in signed N_exposant+2 bits.
REQ-014 LOAD SHALL also register the dividend {1,op1.mantisse} and divisor {1,op2.mantisse}, clear the quotient, and clear the iteration counter.
REQ-015 DIVIDE SHALL perform one restoring-division step per cycle, for exactly N_mantisse+3 cycles; the iteration counter wraps to 0 on exit.
- Each step: trial subtract divisor from remainder; if non-negative, keep the difference and shift in quotient bit 1, else shift in 0; then shift the remainder left by 1.
REQ-016 NORM SHALL normalise on the quotient MSB (integer bit).
- MSB=0: shift the quotient left by 1 and decrement exp.
- The mantissa is the N_mantisse bits below the leading 1; the next bit is the guard bit.
REQ-017 Saturation, evaluated after rounding:
- op2.exposant==0: result = {sign, 2**N_exposant-2, all ones} and div_zero=1.
- Otherwise, op1.exposant==0 or exp<1: result = {sign, 0, 0}.
- Otherwise, exp>2**N_exposant-2: result = {sign, 2**N_exposant-2, all ones}.
REQ-018 DONE SHALL drive done=1 for one cycle and return to IDLE.
- Latency is fixed: done is high exactly N_mantisse+6 cycles after the edge at which start was sampled, including all special-case operands.
REQ-019 Back-to-back operation: start may be asserted in the cycle done is high, but is accepted only on the following IDLE cycle.

Reset
REQ-020 reset=1 at any edge, including mid-operation, SHALL force IDLE with busy=0, done=0, div_zero=0, result=0, and all internal registers cleared.
- No partial result is ever emitted after a reset.

Configuration
REQ-021 Macro FLOAT_DIV_ROUND_EN: when defined, NORM SHALL round half-up by adding the guard bit to the mantissa.
- A rounding carry out of an all-ones mantissa clears the mantissa and increments exp before the saturation check.
- When the macro is undefined, the mantissa is truncated and the guard bit is ignored.
- Latency is identical in both builds.

Structure
REQ-022 float, N_mantisse, N_exposant and the constants D_e = 2**(N_exposant-1)-1, EXP_MIN = 1 and EXP_MAX = 2**N_exposant-2 SHALL live in float_pack.
- The FSM state enum SHALL also be added to float_pack.
REQ-023 The mantissa datapath (restoring divider: remainder, quotient, counter) SHALL be a sub-module float_div_mant.
- Its interface is load/step in and quotient out; float_div keeps the sign/exponent logic, normalisation, saturation and the FSM.

Verification (N_exposant=8, N_mantisse=23; values are IEEE bit patterns)
REQ-024 6.0/2.0 (0x40C00000/0x40000000): result 0x40400000; done exactly 29 cycles after start; busy high throughout.
REQ-025 1.0/3.0: result 0x3EAAAAAA without FLOAT_DIV_ROUND_EN and 0x3EAAAAAB with it.
REQ-026 1.0/0.0: result 0x7F7FFFFF with div_zero=1; 3.0e38/0.5: result 0x7F7FFFFF with div_zero=0.
- 2.0e-38/4.0: result 0x00000000.
- -8.0/2.0: result 0xC0800000.
REQ-027 Reset pulsed 10 cycles after start: the next cycle shows busy=0, result=0, and no done pulse ever appears for that request; a new 6.0/2.0 then completes normally.
REQ-028 start held high continuously for 100 cycles with fixed operands: done pulses every 31 cycles (29-cycle latency + DONE + IDLE), and each start while busy has no effect.
